// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised 1RW+1R SRAM: default geometry,
// sequencer state type and the lane-merge helper used by the write-through
// bypass on port 1.
package sram_pkg;

  // Default geometry, matching the 32x512 hard macro this block replaces.
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_LANE_WIDTH = 8;

  // Widest word the merge helper handles; instances must stay at or below it.
  localparam int MERGE_MAX_WIDTH = 1024;

  // Array lifecycle: zero-fill after reset, then normal port service.
  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sram_state_e;

  typedef logic [MERGE_MAX_WIDTH-1:0] merge_word_t;

  // Replace the bits of old_word selected by bit_mask with new_word.
  // bit_mask is the per-lane write mask expanded to one bit per data bit,
  // so a set lane carries the incoming data and a clear lane keeps the old.
  function automatic merge_word_t lane_merge(
    input merge_word_t old_word,
    input merge_word_t new_word,
    input merge_word_t bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset zero-fill sequencer. Walks the fill address from 0 to DEPTH-1,
// one word per clock, then hands the array over to the ports by raising
// o_init_done. Any synchronous reset restarts the walk from address 0.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_fill_en,
  output logic [ADDR_WIDTH-1:0] o_fill_addr,
  output logic                  o_init_done
);

  localparam logic [0:0] ST_INIT = S_INIT;
  localparam logic [0:0] ST_RUN  = S_RUN;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;

  // Fill state machine: advance one address per cycle, leave INIT after the last word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_cnt == LAST_ADDR) begin
        r_state <= ST_RUN;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The reset cycle itself writes nothing; filling starts on the first edge after it.
  assign o_fill_en   = (r_state == ST_INIT) && !rst;
  assign o_fill_addr = r_cnt;
  assign o_init_done = (r_state == ST_RUN);

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R synchronous SRAM, single clock.
//   Port 0: active-low select/write enable, per-lane write mask, registered read.
//   Port 1: active-low select, registered read.
// Reads have one cycle of latency and a one-cycle valid pulse; outputs hold the
// last read word otherwise. After reset the array is zero-filled one word per
// cycle and all port requests are ignored until init_done rises.
// Build option: define SRAM_BYPASS_EN to make a port 1 read that collides with a
// port 0 write on the same edge return the merged new word; without it the read
// returns the old word, as the hard macro does.
// DATA_WIDTH must be an exact multiple of LANE_WIDTH and at most MERGE_MAX_WIDTH.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int LANE_WIDTH = SRAM_LANE_WIDTH,
  localparam int DEPTH      = 2 ** ADDR_WIDTH,
  localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  init_done
);

  logic                  w_fill_en;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic                  w_init_done;

  logic                  w_run;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;

  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [NUM_WMASKS-1:0] w_wr_lanes;

  logic [DATA_WIDTH-1:0] w_rd0_word;
  logic [DATA_WIDTH-1:0] w_rd1_word;
  logic [DATA_WIDTH-1:0] w_rd1_data;

  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_dout0_valid;
  logic                  r_dout1_valid;

  sram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk         (clk),
    .rst         (rst),
    .o_fill_en   (w_fill_en),
    .o_fill_addr (w_fill_addr),
    .o_init_done (w_init_done)
  );

  // Ports are only serviced once the fill is complete and not while reset is held.
  assign w_run = w_init_done && !rst;
  assign w_wr0 = w_run && !csb0 && !web0;
  assign w_rd0 = w_run && !csb0 &&  web0;
  assign w_rd1 = w_run && !csb1;

  // Single array write port, shared between the zero-fill sequencer and port 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    w_wr_addr  = addr0;
    w_wr_data  = din0;
    w_wr_lanes = '0;
    if (w_fill_en) begin
      w_wr_addr  = w_fill_addr;
      w_wr_data  = '0;
      w_wr_lanes = '1;
    end else if (w_wr0) begin
      w_wr_lanes = wmask0;
    end
  end

  // One storage column per write-mask lane, so a masked write touches only its lanes.
  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
    logic [LANE_WIDTH-1:0] r_mem [DEPTH];

    // Lane write; the array itself is never reset, the sequencer clears it.
    always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset branch; SRAM cells cannot be
      // cleared in one cycle, which is exactly why the zero-fill sequencer exists.
      if (w_wr_lanes[g]) begin
        r_mem[w_wr_addr] <= w_wr_data[g*LANE_WIDTH +: LANE_WIDTH];
      end
    end

    assign w_rd0_word[g*LANE_WIDTH +: LANE_WIDTH] = r_mem[addr0];
    assign w_rd1_word[g*LANE_WIDTH +: LANE_WIDTH] = r_mem[addr1];
  end

`ifdef SRAM_BYPASS_EN
  logic [DATA_WIDTH-1:0] w_bit_mask;
  logic                  w_collide;

  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_mask
    assign w_bit_mask[g*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[g]}};
  end

  // Same-edge write to the address port 1 is reading: forward the merged word.
  assign w_collide  = w_wr0 && (addr0 == addr1);
  assign w_rd1_data = w_collide
                    ? DATA_WIDTH'(lane_merge(merge_word_t'(w_rd1_word),
                                             merge_word_t'(din0),
                                             merge_word_t'(w_bit_mask)))
                    : w_rd1_word;
`else
  // The array still holds the pre-edge word, so a colliding read sees old data.
  assign w_rd1_data = w_rd1_word;
`endif

  // Read pipeline: capture on request, hold otherwise; valid pulses once per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout0       <= '0;
      r_dout1       <= '0;
      r_dout0_valid <= 1'b0;
      r_dout1_valid <= 1'b0;
    end else begin
      r_dout0_valid <= w_rd0;
      r_dout1_valid <= w_rd1;
      if (w_rd0) begin
        r_dout0 <= w_rd0_word;
      end
      if (w_rd1) begin
        r_dout1 <= w_rd1_data;
      end
    end
  end

  assign dout0       = r_dout0;
  assign dout1       = r_dout1;
  assign dout0_valid = r_dout0_valid;
  assign dout1_valid = r_dout1_valid;
  assign init_done   = w_init_done;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param at its default 32x512, 8-bit-lane geometry.
// Directed table, zero-fill timing, reset mid-run and a randomised run checked
// against a word-array reference model.
module tb_sram_1rw1r_param;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LW    = 8;
  localparam int NW    = DW / LW;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          csb0;
  logic          web0;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          dout0_valid;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          init_done;

  sram_1rw1r_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LANE_WIDTH (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory as a plain word array, init progress as a cycle count.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] m_d0, m_d1;
  logic          m_v0, m_v1;
  int            m_cyc;

  typedef struct {
    logic          csb0;
    logic          web0;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] e_d0;
    logic          e_v0;
    logic [DW-1:0] e_d1;
    logic          e_v1;
  } vec_t;

  localparam int NTBL = 14;
  vec_t tbl [NTBL];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    csb1   = 1'b1;
    addr1  = '0;
  endtask

  // Apply the current inputs to the model as one clock edge.
  task automatic model_step();
    logic [DW-1:0] old0, old1, bm, merged;
    logic          wr;
    if (rst) begin
      m_d0 = '0; m_d1 = '0; m_v0 = 1'b0; m_v1 = 1'b0; m_cyc = 0;
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    end else if (m_cyc < DEPTH) begin
      m_cyc++;
      m_v0 = 1'b0;
      m_v1 = 1'b0;
    end else begin
      old0 = ref_mem[addr0];
      old1 = ref_mem[addr1];
      bm = '0;
      for (int i = 0; i < NW; i++)
        if (wmask0[i]) bm = bm | (((DW'(1) << LW) - DW'(1)) << (i * LW));
      wr = !csb0 && !web0;
      m_v0 = !csb0 && web0;
      m_v1 = !csb1;
      if (m_v0) m_d0 = old0;
      if (m_v1) begin
        m_d1 = old1;
`ifdef SRAM_BYPASS_EN
        if (wr && addr0 == addr1) m_d1 = (old1 & ~bm) | (din0 & bm);
`endif
      end
      if (wr) begin
        merged = (ref_mem[addr0] & ~bm) | (din0 & bm);
        ref_mem[addr0] = merged;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Release reset and count cycles until init_done; optionally poke the ports at fill cycle 10.
  task automatic run_init(input bit inject);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    for (int k = 0; k < DEPTH + 16; k++) begin
      if (init_done === 1'b1) break;
      cnt++;
      if (inject && k == 10) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = '1; addr0 = AW'(3); din0 = 32'h12345678;
        csb1 = 1'b0; addr1 = AW'(3);
      end else begin
        idle();
      end
      tick();
      if (inject && k == 10) begin
        check("init_req_v0", DW'(dout0_valid), DW'(0));
        check("init_req_v1", DW'(dout1_valid), DW'(0));
      end else if (dout0_valid !== 1'b0 || dout1_valid !== 1'b0) begin
        check($sformatf("init_valid_%0d", k), DW'({dout0_valid, dout1_valid}), DW'(0));
      end
    end
    idle();
    check("init_len", DW'(cnt), DW'(DEPTH));
    check("init_done_hi", DW'(init_done), DW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout0"}, dout0, '0);
    check({tag, "_dout1"}, dout1, '0);
    check({tag, "_v0"}, DW'(dout0_valid), DW'(0));
    check({tag, "_v1"}, DW'(dout1_valid), DW'(0));
    check({tag, "_done"}, DW'(init_done), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] byp_7, byp_9;
`ifdef SRAM_BYPASS_EN
    byp_7 = 32'h55555555;
    byp_9 = 32'h00005678;
`else
    byp_7 = 32'hAAAAAAAA;
    byp_9 = 32'h00000000;
`endif
    //          csb0  web0  mask    a0       din0          csb1  a1        d0            v0    d1            v1
    tbl[0]  = '{1'b0, 1'b1, 4'h0, 9'd0,   32'h0,        1'b0, 9'd255, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 4'h0, 9'd511, 32'h0,        1'b1, 9'd0,   32'h00000000, 1'b1, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 9'd3,   32'h0,        1'b0, 9'd3,   32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, 9'd5,   32'hDEADBEEF, 1'b1, 9'd0,   32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 9'd5,   32'h0,        1'b0, 9'd5,   32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 4'h0, 9'd0,   32'h0,        1'b1, 9'd0,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h5, 9'd5,   32'h11223344, 1'b1, 9'd0,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 9'd5,   32'h0,        1'b0, 9'd5,   32'hDE22BE44, 1'b1, 32'hDE22BE44, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 9'd5,   32'hFFFFFFFF, 1'b1, 9'd0,   32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 9'd5,   32'h0,        1'b1, 9'd0,   32'hDE22BE44, 1'b1, 32'hDE22BE44, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 9'd7,   32'hAAAAAAAA, 1'b1, 9'd0,   32'hDE22BE44, 1'b0, 32'hDE22BE44, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 9'd7,   32'h55555555, 1'b0, 9'd7,   32'hDE22BE44, 1'b0, byp_7,        1'b1};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 9'd7,   32'h0,        1'b0, 9'd7,   32'h55555555, 1'b1, 32'h55555555, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'h3, 9'd9,   32'h12345678, 1'b0, 9'd9,   32'h55555555, 1'b0, byp_9,        1'b1};

    // Reset state.
    idle();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");

    // Zero-fill timing, with a write/read attempted during the fill.
    run_init(1'b1);

    // Directed table.
    for (int t = 0; t < NTBL; t++) begin
      csb0 = tbl[t].csb0; web0 = tbl[t].web0; wmask0 = tbl[t].wmask0;
      addr0 = tbl[t].addr0; din0 = tbl[t].din0;
      csb1 = tbl[t].csb1; addr1 = tbl[t].addr1;
      tick();
      check($sformatf("tbl%0d_dout0", t), dout0, tbl[t].e_d0);
      check($sformatf("tbl%0d_v0", t), DW'(dout0_valid), DW'(tbl[t].e_v0));
      check($sformatf("tbl%0d_dout1", t), dout1, tbl[t].e_d1);
      check($sformatf("tbl%0d_v1", t), DW'(dout1_valid), DW'(tbl[t].e_v1));
    end
    idle();

    // Randomised traffic on a small hot address set plus occasional far addresses.
    for (int r = 0; r < 3000; r++) begin
      csb0   = ($urandom_range(0, 4) == 0);
      web0   = ($urandom_range(0, 1) == 0);
      wmask0 = NW'($urandom_range(0, 15));
      din0   = $urandom();
      csb1   = ($urandom_range(0, 4) == 0);
      addr0  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      addr1  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      tick();
      check($sformatf("rnd%0d_dout0", r), dout0, m_d0);
      check($sformatf("rnd%0d_v0", r), DW'(dout0_valid), DW'(m_v0));
      check($sformatf("rnd%0d_dout1", r), dout1, m_d1);
      check($sformatf("rnd%0d_v1", r), DW'(dout1_valid), DW'(m_v1));
      check($sformatf("rnd%0d_done", r), DW'(init_done), DW'(m_cyc >= DEPTH));
    end
    idle();

    // Put known data back at 5 and 7, then a one-cycle reset mid-run.
    csb0 = 1'b0; web0 = 1'b0; wmask0 = '1; addr0 = AW'(5); din0 = 32'hCAFEF00D;
    tick();
    addr0 = AW'(7); din0 = 32'h0BADC0DE;
    tick();
    csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(5);
    tick();
    check("pre_rst_rd5", dout0, 32'hCAFEF00D);
    idle();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    run_init(1'b0);

    // Contents re-zeroed by the restarted fill.
    csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(5); csb1 = 1'b0; addr1 = AW'(7);
    tick();
    check("post_rst_rd5", dout0, '0);
    check("post_rst_v0", DW'(dout0_valid), DW'(1));
    check("post_rst_rd7", dout1, '0);
    check("post_rst_v1", DW'(dout1_valid), DW'(1));
    idle();
    tick();
    check("post_rst_v0_pulse", DW'(dout0_valid), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised, synthesisable 1RW+1R SRAM with a registered read pipeline, output-valid strobes and a post-reset zero-fill sequencer. Successor to the fixed 32x512 OpenRAM macro: same port semantics (active-low chip select and write enable, per-lane write mask), generalised in width, depth and mask granularity, and driven from a single clock. Used as the on-chip storage for the tile when the hard macro is unavailable or mis-sized.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH (localparam)
- LANE_WIDTH, 8, bits per write-mask lane; DATA_WIDTH must be a multiple; NUM_WMASKS = DATA_WIDTH/LANE_WIDTH (localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- csb0  in  1  port 0 select, active low
- web0  in  1  port 0 write enable, active low
- wmask0  in  NUM_WMASKS  lane write mask, 1 = write lane
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_valid  out  1  dout0 updated by a read this cycle
- csb1  in  1  port 1 select, active low
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data
- dout1_valid  out  1  dout1 updated by a read this cycle
- init_done  out  1  zero-fill complete, array usable

## Operation
- States: INIT, RUN. rst forces INIT, init counter = 0.
- INIT: one word per cycle written with all zeros, address = counter, 0 to DEPTH-1; after writing DEPTH-1 go to RUN, init_done = 1. All port requests ignored (no write, no valid).
- RUN, port 0: csb0=0, web0=0 -> lanes with wmask0[i]=1 take din0 lane i; other lanes unchanged; dout0/dout0_valid not affected (valid = 0). csb0=0, web0=1 -> read addr0. csb0=1 -> idle.
- RUN, port 1: csb1=0 -> read addr1; csb1=1 -> idle.
- Idle or write cycle: dout holds last read value, valid = 0.
- Port 0 write + port 1 read, same address, same edge: port 1 returns per Configuration.
- wmask0 = 0 with web0=0: no array change, no valid.
- No wrap concerns: addresses span the full 2**ADDR_WIDTH range.

## Timing
- Reset values: dout0 = 0, dout1 = 0, dout0_valid = 0, dout1_valid = 0, init_done = 0.
- Init: rst deasserted at edge R -> init_done rises after edge R+DEPTH (DEPTH cycles of fill).
- rst during INIT or RUN: restart fill from address 0; contents are re-zeroed.
- Read latency 1: request sampled at edge N; dout/valid updated at edge N, visible throughout cycle N+1; valid is a single-cycle pulse per request.
- Back-to-back reads on both ports every cycle, full throughput.
- Write visible to a port 0 read issued at the next edge.

## Configuration
- SRAM_BYPASS_EN defined: same-edge port 0 write / port 1 read to equal address -> dout1 = old word with masked lanes replaced by din0 (new data).
- Undefined: dout1 = old word (read-before-write), matching the hard macro.

## Structure
- Package sram_pkg: default DATA_WIDTH/ADDR_WIDTH/LANE_WIDTH constants, state enum (INIT, RUN), lane-merge function (old, new, mask).
- Sub-module sram_init_seq: INIT/RUN FSM, fill counter, init_done; drives fill address/enable into the array write mux.

## Test plan
- Reset then release -> init_done low for exactly 512 cycles, high after; reads of addr 0, 255 and 511 return 0x00000000 with dout0_valid one-cycle pulse.
- Write 0xDEADBEEF to addr 5, wmask0=4'b1111, then port 0 read addr 5 -> dout0 = 0xDEADBEEF one cycle later; port 1 read addr 5 same -> dout1 = 0xDEADBEEF.
- Addr 5 = 0xDEADBEEF; write 0x11223344, wmask0=4'b0101 -> readback 0xDE22BE44.
- Addr 7 = 0xAAAAAAAA; same-edge write 0x55555555 full mask + port 1 read addr 7 -> dout1 = 0x55555555 with SRAM_BYPASS_EN, 0xAAAAAAAA without; next read = 0x55555555 in both.
- Request during INIT (write 0x12345678 to addr 3 at fill cycle 10) -> no valid, addr 3 reads 0 after init_done.
- Assert rst for 1 cycle mid-RUN after writes -> all outputs 0, init_done low for 512 cycles, previously written addr 5 reads 0.
